// File: rtl/fifo_uart_tx_drain_pkg.sv
// fifo_uart_pkg: FSM encoding and default sizing shared by the FIFO UART drain.
package fifo_uart_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_CLKS_PER_BIT = 16;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_e;
endpackage

// File: rtl/fifo_uart_tx_drain_baud_tick_gen.sv
// baud_tick_gen: bit-period counter with clear; tick_o pulses for one cycle at CLKS_PER_BIT-1.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign tick_o = cnt_q == CNT_W'(CLKS_PER_BIT - 1);
  always_comb cnt_d = (clr_i || tick_o) ? '0 : cnt_q + CNT_W'(1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/fifo_uart_tx_drain.sv
// fifo_uart_tx_drain: pops bytes from a sync FIFO and sends them as 8N1 UART frames.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module fifo_uart_tx_drain
  import fifo_uart_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_re,
  output logic              tx,
  output logic              busy
);
  localparam int BIT_W = $clog2(DATA_W + 1);
  state_e state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic tx_q, tx_d, re_q, re_d, busy_q, busy_d;
  logic tick, last_tx;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam state_e AFTER_DATA = PARITY;
  logic par_q, par_d;
  assign last_tx = par_q;
  always_comb par_d = state_q == LOAD ? ^fifo_dout : par_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_q <= 1'b0;
    else par_q <= par_d;
  end
`else
  localparam state_e AFTER_DATA = STOP;
  assign last_tx = 1'b1;
`endif
  // Period counter is held clear until the start bit so START spans exactly one bit.
  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT), .CNT_W(CNT_W)) u_tick (
    .clk(clk),
    .rst(rst),
    .clr_i(state_q inside {IDLE, FETCH, LOAD}),
    .tick_o(tick)
  );
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d = bit_q;
    tx_d = tx_q;
    re_d = 1'b0;
    busy_d = busy_q;
    case (state_q)
      IDLE: if (!fifo_empty) begin
        re_d = 1'b1;
        busy_d = 1'b1;
        state_d = FETCH;
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        shift_d = fifo_dout;
        tx_d = 1'b0;
        bit_d = '0;
        state_d = START;
      end
      START: if (tick) begin
        tx_d = shift_q[0];
        state_d = DATA;
      end
      DATA: if (tick) begin
        shift_d = shift_q >> 1;
        bit_d = bit_q + BIT_W'(1);
        tx_d = bit_q == BIT_W'(DATA_W - 1) ? last_tx : shift_q[1];
        state_d = bit_q == BIT_W'(DATA_W - 1) ? AFTER_DATA : DATA;
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: if (tick) begin
        tx_d = 1'b1;
        state_d = STOP;
      end
`endif
      STOP: if (tick) begin
        re_d = !fifo_empty;
        busy_d = !fifo_empty;
        state_d = fifo_empty ? IDLE : FETCH;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q <= '0;
      tx_q <= 1'b1;
      re_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q <= bit_d;
      tx_q <= tx_d;
      re_q <= re_d;
      busy_q <= busy_d;
    end
  end
  assign fifo_re = re_q;
  assign tx = tx_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_fifo_uart_tx_drain.sv
// tb_fifo_uart_tx_drain: directed checks of the UART drain behind a 16-deep FIFO model.
module tb_fifo_uart_tx_drain;
  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] fifo_dout = 8'h00;
  logic fifo_empty, fifo_re, tx, busy;
  int n_cmp = 0, n_err = 0, re_cnt = 0, re_empty = 0;
  logic [7:0] mem [16];
  logic [3:0] wp = 4'd0, rp = 4'd0;
  logic [4:0] cnt = 5'd0;
  logic wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  assign fifo_empty = cnt == 5'd0;
  always #5 clk = ~clk;
  // Synchronous FIFO: read data appears the cycle after fifo_re is sampled.
  always @(posedge clk) begin
    if (wr_en) begin
      mem[wp] <= wr_data;
      wp <= wp + 4'd1;
    end
    if (fifo_re && cnt != 5'd0) begin
      fifo_dout <= mem[rp];
      rp <= rp + 4'd1;
    end
    cnt <= cnt + 5'(wr_en) - 5'(fifo_re && cnt != 5'd0);
    if (fifo_re) re_cnt <= re_cnt + 1;
    if (fifo_re && fifo_empty) re_empty <= re_empty + 1;
  end
  fifo_uart_tx_drain #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst(rst),
    .fifo_dout(fifo_dout),
    .fifo_empty(fifo_empty),
    .fifo_re(fifo_re),
    .tx(tx),
    .busy(busy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [7:0] b);
    wr_data = b;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask
  // Waits for the pop, then checks every bit at its first and last cycle; returns at stop-bit end.
  task automatic frame(input logic [7:0] b, input string tag);
    int n = 0;
    logic [FB-1:0] bits;
`ifdef FIFO_UART_TX_PARITY_EN
    bits = {1'b1, ^b, b, 1'b0};
`else
    bits = {1'b1, b, 1'b0};
`endif
    while (!fifo_re && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " re"}, 32'(fifo_re), 1);
    chk({tag, " busy"}, 32'(busy), 1);
    @(negedge clk);
    chk({tag, " re pulse"}, 32'(fifo_re), 0);
    chk({tag, " fetch tx"}, 32'(tx), 1);
    @(negedge clk);
    for (int k = 0; k < FB; k++)
      for (int c = 0; c < CPB; c++) begin
        if (c == 0 || c == CPB - 1) chk({tag, " bit"}, 32'(tx), 32'(bits[k]));
        @(negedge clk);
      end
  endtask
  initial begin
    int r, n;
    logic ok;
    repeat (3) @(negedge clk);
    chk("rst tx", 32'(tx), 1);
    chk("rst re", 32'(fifo_re), 0);
    chk("rst busy", 32'(busy), 0);
    rst = 1'b0;
    ok = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || fifo_re !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    chk("idle quiet", 32'(ok), 1);
    r = re_cnt;
    push(8'hA5);
    frame(8'hA5, "a5");
    chk("a5 busy drop", 32'(busy), 0);
    chk("a5 tx idle", 32'(tx), 1);
    chk("a5 pops", 32'(re_cnt - r), 1);
    chk("a5 empty", 32'(fifo_empty), 1);
    r = re_cnt;
    fork
      begin
        push(8'h00);
        push(8'hFF);
        push(8'h3C);
      end
      begin
        frame(8'h00, "b2b0");
        chk("b2b gap0", 32'(fifo_re), 1);
        frame(8'hFF, "b2b1");
        chk("b2b gap1", 32'(fifo_re), 1);
        frame(8'h3C, "b2b2");
      end
    join
    chk("b2b busy drop", 32'(busy), 0);
    chk("b2b pops", 32'(re_cnt - r), 3);
    r = re_cnt;
    fork
      for (int i = 0; i < 16; i++) push(8'(i));
      for (int j = 0; j < 16; j++) frame(8'(j), "seq");
    join
    chk("seq pops", 32'(re_cnt - r), 16);
    chk("seq empty", 32'(fifo_empty), 1);
    chk("seq busy drop", 32'(busy), 0);
    push(8'h81);
    n = 0;
    while (!fifo_re && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rst81 re", 32'(fifo_re), 1);
    repeat (2 + 4 * CPB + 1) @(negedge clk);
    chk("rst81 bit3", 32'(tx), 0);
    #2 rst = 1'b1;
    #1;
    chk("async tx", 32'(tx), 1);
    chk("async busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    r = re_cnt;
    repeat (30) @(negedge clk);
    chk("post rst pops", 32'(re_cnt - r), 0);
    chk("post rst tx", 32'(tx), 1);
    chk("post rst busy", 32'(busy), 0);
`ifdef FIFO_UART_TX_PARITY_EN
    push(8'h07);
    frame(8'h07, "par07");
    chk("par07 busy drop", 32'(busy), 0);
    push(8'h03);
    frame(8'h03, "par03");
    chk("par03 busy drop", 32'(busy), 0);
`endif
    chk("no pop while empty", 32'(re_empty), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
